serial_subtractor: RTL

//  Multi-cycle bit-serial subtractor: computes Q = A - B - bin one bit per clock, LSB first.

---
 rtl/arith_pkg.sv | 10 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 91 +++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic lab datapath: FSM encodings and default operand width.
package arith_pkg;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first: Q = A - B - bin over WIDTH enabled cycles,
// with a start/busy handshake and a one-cycle done strobe.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   Q
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [WIDTH-1:0] res;
   logic             br;
   logic             d;
   logic             bout;
   logic [WIDTH:0]   shifted;

   full_subtractor u_fs (
      .a    (areg[0]),
      .b    (breg[0]),
      .bin  (br),
      .d    (d),
      .bout (bout)
   );

   // New difference bit enters at the MSB; slicing [WIDTH:1] also works for WIDTH=1.
   assign shifted = {d, res};
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         areg  <= '0;
         breg  <= '0;
         res   <= '0;
         br    <= 1'b0;
         done  <= 1'b0;
         Q     <= '0;
      end else if (enable) begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  areg  <= A;
                  breg  <= B;
                  br    <= bin;
                  res   <= '0;
                  cnt   <= '0;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               areg <= areg >> 1;
               breg <= breg >> 1;
               br   <= bout;
               res  <= shifted[WIDTH:1];
               cnt  <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state <= ST_DONE;
                  Q     <= {bout, shifted[WIDTH:1]};
                  done  <= 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
